// File: rtl/issue_scoreboard_pkg.sv
// Shared widths, issued-instruction bundle and a one-hot helper for the issue scoreboard.
package issue_scoreboard_pkg;

    localparam int unsigned REG_NUM_W    = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned NUM_SRCS     = 3;
    localparam int unsigned FILE_COUNT_W = 6;
    localparam int unsigned COUNT_W      = 7;

    typedef struct packed {
        logic [INSTR_W-1:0]   instruction;
        logic [REG_NUM_W-1:0] out_reg_num;
        logic                 out_general_reg;
        logic                 out_float_reg;
    } iss_bundle_t;

    // One-hot mask of a register index, or all-zero when not enabled.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input logic [REG_NUM_W-1:0] num);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (en) begin
            mask[num] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decoder-side, issue-side, writeback and status signals of the issue scoreboard.
// master: the environment driving the scoreboard; slave: the scoreboard itself.
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    logic                                dec_valid;
    logic                                dec_ready;
    logic [INSTR_W-1:0]                  dec_instruction;
    logic [NUM_SRCS-1:0][REG_NUM_W-1:0]  dec_in_reg_num;
    logic [REG_NUM_W-1:0]                dec_out_reg_num;
    logic                                dec_out_general_reg;
    logic                                dec_out_float_reg;

    logic                                iss_valid;
    logic                                iss_ready;
    logic [INSTR_W-1:0]                  iss_instruction;
    logic [REG_NUM_W-1:0]                iss_out_reg_num;
    logic                                iss_out_general_reg;
    logic                                iss_out_float_reg;

    logic                                wb_gen_en;
    logic [REG_NUM_W-1:0]                wb_gen_num;
    logic                                wb_float_en;
    logic [REG_NUM_W-1:0]                wb_float_num;

    logic                                flush;
    logic [COUNT_W-1:0]                  pending_count;

    modport master (
        output dec_valid, dec_instruction, dec_in_reg_num, dec_out_reg_num,
               dec_out_general_reg, dec_out_float_reg,
        output iss_ready,
        output wb_gen_en, wb_gen_num, wb_float_en, wb_float_num,
        output flush,
        input  dec_ready,
        input  iss_valid, iss_instruction, iss_out_reg_num, iss_out_general_reg, iss_out_float_reg,
        input  pending_count
    );

    modport slave (
        input  dec_valid, dec_instruction, dec_in_reg_num, dec_out_reg_num,
               dec_out_general_reg, dec_out_float_reg,
        input  iss_ready,
        input  wb_gen_en, wb_gen_num, wb_float_en, wb_float_num,
        input  flush,
        output dec_ready,
        output iss_valid, iss_instruction, iss_out_reg_num, iss_out_general_reg, iss_out_float_reg,
        output pending_count
    );

endinterface

// File: rtl/issue_scoreboard_reg_pending_file.sv
// Pending-bit vector for one register file: set/clear, three source lookups,
// one destination lookup and the population count of next-cycle state.
// Optional: ISSUE_SCOREBOARD_WB_BYPASS_EN makes lookups see same-cycle clears.
module reg_pending_file
    import issue_scoreboard_pkg::*;
#(
    parameter bit ZERO_HARDWIRED = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr_all,
    input  logic                               set_en,
    input  logic [REG_NUM_W-1:0]               set_num,
    input  logic                               clr_en,
    input  logic [REG_NUM_W-1:0]               clr_num,
    input  logic [NUM_SRCS-1:0][REG_NUM_W-1:0] src_num,
    input  logic [REG_NUM_W-1:0]               dst_num,
    output logic [NUM_SRCS-1:0]                src_pend_c,
    output logic                               dst_pend_c,
    output logic [FILE_COUNT_W-1:0]            count_next_c
);

    localparam logic [NUM_REGS-1:0] KEEP_MASK = ZERO_HARDWIRED ? ~NUM_REGS'(1) : '1;

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] view;

    assign set_mask = reg_onehot(set_en, set_num) & KEEP_MASK;
    assign clr_mask = reg_onehot(clr_en, clr_num);

    // Next state: flush clears everything, otherwise a set beats a same-cycle clear.
    always_comb begin
        pend_next = ((pend & ~clr_mask) | set_mask) & KEEP_MASK;
        if (clr_all) begin
            pend_next = '0;
        end
    end

    // Pending vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    assign view = pend & ~clr_mask;
`else
    assign view = pend;
`endif

    // Hazard lookups against the (optionally bypassed) pending view.
    always_comb begin
        src_pend_c = '0;
        for (int i = 0; i < int'(NUM_SRCS); i++) begin
            src_pend_c[i] = view[src_num[i]];
        end
        dst_pend_c = view[dst_num];
    end

    // Population count of the state this file will hold next cycle.
    always_comb begin
        count_next_c = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            count_next_c = count_next_c + FILE_COUNT_W'(pend_next[i]);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: holds decoded instructions back on register hazards and presents
// them through a one-entry valid/ready register. General r0 is never pending.
// Optional: ISSUE_SCOREBOARD_WB_BYPASS_EN lets a writeback release a stall in the same cycle.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
(
    input logic               clk,
    input logic               rst,
    issue_scoreboard_if.slave bus
);

    logic [NUM_SRCS-1:0]     gen_src_pend;
    logic [NUM_SRCS-1:0]     flt_src_pend;
    logic                    gen_dst_pend;
    logic                    flt_dst_pend;
    logic [FILE_COUNT_W-1:0] gen_count_next;
    logic [FILE_COUNT_W-1:0] flt_count_next;
    logic                    hazard_c;
    logic                    ready_c;
    logic                    accept_c;
    logic                    iss_valid_q;
    iss_bundle_t             iss_q;
    logic [COUNT_W-1:0]      count_q;

    reg_pending_file #(.ZERO_HARDWIRED(1'b1)) u_gen_file (
        .clk          (clk),
        .rst          (rst),
        .clr_all      (bus.flush),
        .set_en       (accept_c && bus.dec_out_general_reg),
        .set_num      (bus.dec_out_reg_num),
        .clr_en       (bus.wb_gen_en),
        .clr_num      (bus.wb_gen_num),
        .src_num      (bus.dec_in_reg_num),
        .dst_num      (bus.dec_out_reg_num),
        .src_pend_c   (gen_src_pend),
        .dst_pend_c   (gen_dst_pend),
        .count_next_c (gen_count_next)
    );

    reg_pending_file #(.ZERO_HARDWIRED(1'b0)) u_float_file (
        .clk          (clk),
        .rst          (rst),
        .clr_all      (bus.flush),
        .set_en       (accept_c && bus.dec_out_float_reg),
        .set_num      (bus.dec_out_reg_num),
        .clr_en       (bus.wb_float_en),
        .clr_num      (bus.wb_float_num),
        .src_num      (bus.dec_in_reg_num),
        .dst_num      (bus.dec_out_reg_num),
        .src_pend_c   (flt_src_pend),
        .dst_pend_c   (flt_dst_pend),
        .count_next_c (flt_count_next)
    );

    // Conservative hazard: any source pending in either file, or destination pending in its target file.
    always_comb begin
        hazard_c = (|gen_src_pend) || (|flt_src_pend)
                || (bus.dec_out_general_reg && gen_dst_pend)
                || (bus.dec_out_float_reg && flt_dst_pend);
        ready_c  = (!iss_valid_q || bus.iss_ready) && !hazard_c && !bus.flush;
        accept_c = bus.dec_valid && ready_c;
    end

    // One-entry issue register; flush discards it, fields hold while stalled.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else if (accept_c) begin
            iss_valid_q           <= 1'b1;
            iss_q.instruction     <= bus.dec_instruction;
            iss_q.out_reg_num     <= bus.dec_out_reg_num;
            iss_q.out_general_reg <= bus.dec_out_general_reg;
            iss_q.out_float_reg   <= bus.dec_out_float_reg;
        end else if (bus.iss_ready) begin
            iss_valid_q <= 1'b0;
        end
    end

    // Registered count of pending bits across both files.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= COUNT_W'(gen_count_next) + COUNT_W'(flt_count_next);
        end
    end

    assign bus.dec_ready           = ready_c;
    assign bus.iss_valid           = iss_valid_q;
    assign bus.iss_instruction     = iss_q.instruction;
    assign bus.iss_out_reg_num     = iss_q.out_reg_num;
    assign bus.iss_out_general_reg = iss_q.out_general_reg;
    assign bus.iss_out_float_reg   = iss_q.out_float_reg;
    assign bus.pending_count       = count_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; expectations follow ISSUE_SCOREBOARD_WB_BYPASS_EN when defined.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    issue_scoreboard_if bus ();

    issue_scoreboard u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic g, input logic f, input logic [31:0] ins);
        bus.dec_valid           = v;
        bus.dec_in_reg_num[0]   = s0;
        bus.dec_in_reg_num[1]   = s1;
        bus.dec_in_reg_num[2]   = s2;
        bus.dec_out_reg_num     = d;
        bus.dec_out_general_reg = g;
        bus.dec_out_float_reg   = f;
        bus.dec_instruction     = ins;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.iss_ready    = 1'b1;
        bus.flush        = 1'b0;
        bus.wb_gen_en    = 1'b0;
        bus.wb_gen_num   = 5'd0;
        bus.wb_float_en  = 1'b0;
        bus.wb_float_num = 5'd0;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        check("rst_iss_instr", bus.iss_instruction, 32'd0);
        check("rst_iss_dst", 32'(bus.iss_out_reg_num), 32'd0);
        check("rst_iss_gen", 32'(bus.iss_out_general_reg), 32'd0);
        check("rst_iss_flt", 32'(bus.iss_out_float_reg), 32'd0);
        check("rst_count", 32'(bus.pending_count), 32'd0);
        check("rst_dec_ready", 32'(bus.dec_ready), 32'd1);

        // First accept: srcs 1,2,3, dest r4
        drive(1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 32'h1111_1111);
        check("t1_ready", 32'(bus.dec_ready), 32'd1);
        step();
        check("t1_iss_valid", 32'(bus.iss_valid), 32'd1);
        check("t1_iss_instr", bus.iss_instruction, 32'h1111_1111);
        check("t1_iss_dst", 32'(bus.iss_out_reg_num), 32'd4);
        check("t1_iss_gen", 32'(bus.iss_out_general_reg), 32'd1);
        check("t1_count", 32'(bus.pending_count), 32'd1);

        // Reader of r4 stalls until writeback
        drive(1'b1, 5'd4, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h2222_2222);
        check("t2_stall", 32'(bus.dec_ready), 32'd0);
        step();
        check("t2_iss_drained", 32'(bus.iss_valid), 32'd0);
        check("t2_still_stall", 32'(bus.dec_ready), 32'd0);
        bus.wb_gen_en  = 1'b1;
        bus.wb_gen_num = 5'd4;
        #1;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        check("t2_wb_bypass_ready", 32'(bus.dec_ready), 32'd1);
        step();
        bus.wb_gen_en = 1'b0;
        #1;
`else
        check("t2_wb_cycle_stall", 32'(bus.dec_ready), 32'd0);
        step();
        bus.wb_gen_en = 1'b0;
        #1;
        check("t2_count_cleared", 32'(bus.pending_count), 32'd0);
        check("t2_release", 32'(bus.dec_ready), 32'd1);
        step();
`endif
        check("t2_iss_valid", 32'(bus.iss_valid), 32'd1);
        check("t2_iss_instr", bus.iss_instruction, 32'h2222_2222);
        check("t2_count", 32'(bus.pending_count), 32'd1);

        // Destination r0 never becomes pending
        drive(1'b1, 5'd7, 5'd8, 5'd9, 5'd0, 1'b1, 1'b0, 32'h3333_3333);
        check("t3_ready", 32'(bus.dec_ready), 32'd1);
        step();
        check("t3_iss_instr", bus.iss_instruction, 32'h3333_3333);
        check("t3_count", 32'(bus.pending_count), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 32'h4444_4444);
        check("t3_r0_reader", 32'(bus.dec_ready), 32'd1);
        step();
        check("t3_iss_instr2", bus.iss_instruction, 32'h4444_4444);
        check("t3_count2", 32'(bus.pending_count), 32'd2);

        // Backpressure: issue register holds for 3 cycles
        bus.iss_ready = 1'b0;
        drive(1'b1, 5'd11, 5'd12, 5'd13, 5'd14, 1'b0, 1'b1, 32'h5555_5555);
        check("t4_ready_bp", 32'(bus.dec_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_valid", 32'(bus.iss_valid), 32'd1);
            check("t4_hold_instr", bus.iss_instruction, 32'h4444_4444);
            check("t4_hold_dst", 32'(bus.iss_out_reg_num), 32'd10);
            check("t4_hold_ready", 32'(bus.dec_ready), 32'd0);
        end
        bus.iss_ready = 1'b1;
        #1;
        check("t4_ready_release", 32'(bus.dec_ready), 32'd1);
        step();
        check("t4_iss_instr", bus.iss_instruction, 32'h5555_5555);
        check("t4_iss_flt", 32'(bus.iss_out_float_reg), 32'd1);
        check("t4_iss_gen", 32'(bus.iss_out_general_reg), 32'd0);
        check("t4_count", 32'(bus.pending_count), 32'd3);

        // Same-cycle set and clear of f5: set wins
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 32'h6666_6666);
        step();
        check("t5_count_f5", 32'(bus.pending_count), 32'd4);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 32'h7777_7777);
        bus.wb_float_en  = 1'b1;
        bus.wb_float_num = 5'd5;
        #1;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        check("t5_bypass_ready", 32'(bus.dec_ready), 32'd1);
        step();
`else
        check("t5_dst_stall", 32'(bus.dec_ready), 32'd0);
        step();
        check("t5_count_cleared", 32'(bus.pending_count), 32'd3);
        check("t5_iss_empty", 32'(bus.iss_valid), 32'd0);
        check("t5_ready_clear", 32'(bus.dec_ready), 32'd1);
        step();
`endif
        bus.wb_float_en = 1'b0;
        check("t5_set_wins_count", 32'(bus.pending_count), 32'd4);
        check("t5_iss_instr", bus.iss_instruction, 32'h7777_7777);
        drive(1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h8888_8888);
        check("t5_f5_reader_stall", 32'(bus.dec_ready), 32'd0);

        // Clearing an already-clear bit is a no-op
        idle();
        bus.wb_gen_en  = 1'b1;
        bus.wb_gen_num = 5'd20;
        step();
        bus.wb_gen_en = 1'b0;
        check("t5_noop_clear", 32'(bus.pending_count), 32'd4);

        // Fill to 10 pending bits, then flush with a valid instruction
        for (int d = 15; d <= 20; d++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd0, 5'(d), 1'b1, 1'b0, 32'hA000_0000 | 32'(d));
            step();
        end
        check("t6_count10", 32'(bus.pending_count), 32'd10);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0, 32'hBBBB_BBBB);
        bus.flush = 1'b1;
        #1;
        check("t6_flush_ready", 32'(bus.dec_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        idle();
        check("t6_flush_count", 32'(bus.pending_count), 32'd0);
        check("t6_flush_valid", 32'(bus.iss_valid), 32'd0);
        drive(1'b1, 5'd5, 5'd6, 5'd10, 5'd0, 1'b0, 1'b0, 32'hCCCC_CCCC);
        check("t6_post_flush_ready", 32'(bus.dec_ready), 32'd1);
        step();
        check("t6_post_flush_valid", 32'(bus.iss_valid), 32'd1);
        check("t6_post_flush_count", 32'(bus.pending_count), 32'd0);

        // Reset mid-operation drops writeback and accept
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd22, 1'b1, 1'b0, 32'hDDDD_DDDD);
        step();
        check("t7_count_pre", 32'(bus.pending_count), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd23, 1'b1, 1'b0, 32'hEEEE_EEEE);
        bus.wb_gen_en  = 1'b1;
        bus.wb_gen_num = 5'd22;
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.wb_gen_en = 1'b0;
        idle();
        check("t7_count", 32'(bus.pending_count), 32'd0);
        check("t7_iss_valid", 32'(bus.iss_valid), 32'd0);
        check("t7_iss_instr", bus.iss_instruction, 32'd0);
        check("t7_ready", 32'(bus.dec_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
